// File: rtl/tx_app_buf_alloc.sv
// rtl/tx_app_buf_alloc.sv - per-flow TX payload buffer space allocator
// Reads head/tail of the flow, grants when the request fits, advances the tail.

package tcp_pkg;
    localparam int FLOWID_W         = 4;
    localparam int TX_PAYLOAD_PTR_W = 6;
endpackage

module tx_app_buf_alloc
    import tcp_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        app_req_val,
    output logic                        app_req_rdy,
    input  logic [FLOWID_W-1:0]         app_req_flowid,
    input  logic [TX_PAYLOAD_PTR_W:0]   app_req_len,

    output logic                        app_resp_val,
    input  logic                        app_resp_rdy,
    output logic [FLOWID_W-1:0]         app_resp_flowid,
    output logic                        app_resp_ok,
    output logic [TX_PAYLOAD_PTR_W:0]   app_resp_ptr,

    output logic                        head_ptr_rd_req_val,
    output logic [FLOWID_W-1:0]         head_ptr_rd_req_addr,
    input  logic                        head_ptr_rd_req_rdy,
    input  logic                        head_ptr_rd_resp_val,
    input  logic [FLOWID_W-1:0]         head_ptr_rd_resp_addr,
    input  logic [TX_PAYLOAD_PTR_W:0]   head_ptr_rd_resp_data,
    output logic                        head_ptr_rd_resp_rdy,

    output logic                        tail_ptr_rd_req_val,
    output logic [FLOWID_W-1:0]         tail_ptr_rd_req_addr,
    input  logic                        tail_ptr_rd_req_rdy,
    input  logic                        tail_ptr_rd_resp_val,
    input  logic [FLOWID_W-1:0]         tail_ptr_rd_resp_addr,
    input  logic [TX_PAYLOAD_PTR_W:0]   tail_ptr_rd_resp_data,
    output logic                        tail_ptr_rd_resp_rdy,

    output logic                        tail_ptr_wr_req_val,
    output logic [FLOWID_W-1:0]         tail_ptr_wr_req_addr,
    output logic [TX_PAYLOAD_PTR_W:0]   tail_ptr_wr_req_data,
    input  logic                        tail_ptr_wr_req_rdy
);

    localparam logic [TX_PAYLOAD_PTR_W:0] LP_S = {1'b1, {TX_PAYLOAD_PTR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR_TAIL, RESP} state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [FLOWID_W-1:0]         r_flowid;
    logic [TX_PAYLOAD_PTR_W:0]   r_len;
    logic                        r_hd_req_done;
    logic                        r_tl_req_done;
    logic                        r_hd_resp_done;
    logic                        r_tl_resp_done;
    logic [TX_PAYLOAD_PTR_W:0]   r_head;
    logic [TX_PAYLOAD_PTR_W:0]   r_tail;
    logic                        r_grant;
    logic [TX_PAYLOAD_PTR_W:0]   r_new_tail;

    logic                        w_app_req_hs;
    logic                        w_hd_req_hs;
    logic                        w_tl_req_hs;
    logic                        w_hd_resp_hs;
    logic                        w_tl_resp_hs;
    logic                        w_reqs_done;
    logic                        w_reads_done;
    logic [TX_PAYLOAD_PTR_W:0]   w_head_cap;
    logic [TX_PAYLOAD_PTR_W:0]   w_tail_cap;
    logic [TX_PAYLOAD_PTR_W:0]   w_used;
    logic [TX_PAYLOAD_PTR_W:0]   w_free;
    logic                        w_grant;
    logic [TX_PAYLOAD_PTR_W:0]   w_new_tail;
    logic                        w_unused;

    // Response addresses echo the request; nothing here needs them.
    assign w_unused = ^{head_ptr_rd_resp_addr, tail_ptr_rd_resp_addr};

    assign app_req_rdy          = (r_state == IDLE) && !rst;
    assign head_ptr_rd_req_val  = (r_state == RD_REQ) && !r_hd_req_done;
    assign tail_ptr_rd_req_val  = (r_state == RD_REQ) && !r_tl_req_done;
    assign head_ptr_rd_req_addr = r_flowid;
    assign tail_ptr_rd_req_addr = r_flowid;
    // Responses are also drained in IDLE so a read orphaned by reset cannot wedge the port.
    assign head_ptr_rd_resp_rdy = (r_state == IDLE) || ((r_state == RD_RESP) && !r_hd_resp_done);
    assign tail_ptr_rd_resp_rdy = (r_state == IDLE) || ((r_state == RD_RESP) && !r_tl_resp_done);
    assign tail_ptr_wr_req_val  = (r_state == WR_TAIL);
    assign tail_ptr_wr_req_addr = r_flowid;
    assign tail_ptr_wr_req_data = r_new_tail;
    assign app_resp_val         = (r_state == RESP);
    assign app_resp_flowid      = r_flowid;
    assign app_resp_ok          = r_grant;
    assign app_resp_ptr         = r_tail;

    assign w_app_req_hs = app_req_val && app_req_rdy;
    assign w_hd_req_hs  = head_ptr_rd_req_val && head_ptr_rd_req_rdy;
    assign w_tl_req_hs  = tail_ptr_rd_req_val && tail_ptr_rd_req_rdy;
    assign w_hd_resp_hs = (r_state == RD_RESP) && head_ptr_rd_resp_val && head_ptr_rd_resp_rdy;
    assign w_tl_resp_hs = (r_state == RD_RESP) && tail_ptr_rd_resp_val && tail_ptr_rd_resp_rdy;

    assign w_reqs_done  = (r_hd_req_done || w_hd_req_hs) && (r_tl_req_done || w_tl_req_hs);
    assign w_reads_done = (r_hd_resp_done || w_hd_resp_hs) && (r_tl_resp_done || w_tl_resp_hs);

    // Use this cycle's response data when it arrives so the result is ready on capture.
    assign w_head_cap = w_hd_resp_hs ? head_ptr_rd_resp_data : r_head;
    assign w_tail_cap = w_tl_resp_hs ? tail_ptr_rd_resp_data : r_tail;
    assign w_used     = w_tail_cap - w_head_cap;
    assign w_free     = LP_S - w_used;
    assign w_grant    = (r_len <= w_free);
    assign w_new_tail = w_tail_cap + r_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_app_req_hs) w_next = RD_REQ;
            RD_REQ:  if (w_reqs_done) w_next = RD_RESP;
            RD_RESP: if (w_reads_done) w_next = (w_grant && (r_len != '0)) ? WR_TAIL : RESP;
            WR_TAIL: if (tail_ptr_wr_req_rdy) w_next = RESP;
            RESP:    if (app_resp_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flowid       <= '0;
            r_len          <= '0;
            r_hd_req_done  <= 1'b0;
            r_tl_req_done  <= 1'b0;
            r_hd_resp_done <= 1'b0;
            r_tl_resp_done <= 1'b0;
            r_head         <= '0;
            r_tail         <= '0;
            r_grant        <= 1'b0;
            r_new_tail     <= '0;
        end else begin
            if (w_app_req_hs) begin
                r_flowid       <= app_req_flowid;
                r_len          <= app_req_len;
                r_hd_req_done  <= 1'b0;
                r_tl_req_done  <= 1'b0;
                r_hd_resp_done <= 1'b0;
                r_tl_resp_done <= 1'b0;
            end
            if (w_hd_req_hs) r_hd_req_done <= 1'b1;
            if (w_tl_req_hs) r_tl_req_done <= 1'b1;
            if (w_hd_resp_hs) begin
                r_head         <= head_ptr_rd_resp_data;
                r_hd_resp_done <= 1'b1;
            end
            if (w_tl_resp_hs) begin
                r_tail         <= tail_ptr_rd_resp_data;
                r_tl_resp_done <= 1'b1;
            end
            if ((r_state == RD_RESP) && w_reads_done) begin
                r_grant    <= w_grant;
                r_new_tail <= w_new_tail;
            end
        end
    end

endmodule

// File: tb/tb_tx_app_buf_alloc.sv
// tb/tb_tx_app_buf_alloc.sv - scoreboard bench for tx_app_buf_alloc
// Directed allocations with hand-computed results; S=64, 7-bit pointers.

module tb_tx_app_buf_alloc;
    import tcp_pkg::*;

    localparam int PW = TX_PAYLOAD_PTR_W + 1;
    typedef logic [PW-1:0]       ptr_t;
    typedef logic [FLOWID_W-1:0] fid_t;

    typedef struct { fid_t flow; ptr_t data; } ent_t;
    typedef struct { fid_t flow; logic ok; ptr_t ptr; int acc; int lat; } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic app_req_val, app_req_rdy;
    fid_t app_req_flowid;
    ptr_t app_req_len;
    logic app_resp_val, app_resp_rdy, app_resp_ok;
    fid_t app_resp_flowid;
    ptr_t app_resp_ptr;
    logic head_ptr_rd_req_val, head_ptr_rd_req_rdy, head_ptr_rd_resp_val, head_ptr_rd_resp_rdy;
    fid_t head_ptr_rd_req_addr, head_ptr_rd_resp_addr;
    ptr_t head_ptr_rd_resp_data;
    logic tail_ptr_rd_req_val, tail_ptr_rd_req_rdy, tail_ptr_rd_resp_val, tail_ptr_rd_resp_rdy;
    fid_t tail_ptr_rd_req_addr, tail_ptr_rd_resp_addr;
    ptr_t tail_ptr_rd_resp_data;
    logic tail_ptr_wr_req_val, tail_ptr_wr_req_rdy;
    fid_t tail_ptr_wr_req_addr;
    ptr_t tail_ptr_wr_req_data;

    tx_app_buf_alloc dut (
        .clk(clk), .rst(rst),
        .app_req_val(app_req_val), .app_req_rdy(app_req_rdy),
        .app_req_flowid(app_req_flowid), .app_req_len(app_req_len),
        .app_resp_val(app_resp_val), .app_resp_rdy(app_resp_rdy),
        .app_resp_flowid(app_resp_flowid), .app_resp_ok(app_resp_ok), .app_resp_ptr(app_resp_ptr),
        .head_ptr_rd_req_val(head_ptr_rd_req_val), .head_ptr_rd_req_addr(head_ptr_rd_req_addr),
        .head_ptr_rd_req_rdy(head_ptr_rd_req_rdy),
        .head_ptr_rd_resp_val(head_ptr_rd_resp_val), .head_ptr_rd_resp_addr(head_ptr_rd_resp_addr),
        .head_ptr_rd_resp_data(head_ptr_rd_resp_data), .head_ptr_rd_resp_rdy(head_ptr_rd_resp_rdy),
        .tail_ptr_rd_req_val(tail_ptr_rd_req_val), .tail_ptr_rd_req_addr(tail_ptr_rd_req_addr),
        .tail_ptr_rd_req_rdy(tail_ptr_rd_req_rdy),
        .tail_ptr_rd_resp_val(tail_ptr_rd_resp_val), .tail_ptr_rd_resp_addr(tail_ptr_rd_resp_addr),
        .tail_ptr_rd_resp_data(tail_ptr_rd_resp_data), .tail_ptr_rd_resp_rdy(tail_ptr_rd_resp_rdy),
        .tail_ptr_wr_req_val(tail_ptr_wr_req_val), .tail_ptr_wr_req_addr(tail_ptr_wr_req_addr),
        .tail_ptr_wr_req_data(tail_ptr_wr_req_data), .tail_ptr_wr_req_rdy(tail_ptr_wr_req_rdy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_wr    = 0;
    int n_resp  = 0;
    int hd_rdy_dly = 0, hd_resp_dly = 0, tl_rdy_dly = 0, tl_resp_dly = 0, wr_dly = 0, app_dly = 0;

    ent_t hd_q[$];
    ent_t tl_q[$];
    ent_t wr_q[$];
    rsp_t rsp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Head pointer table responder
    initial begin
        ent_t e;
        int n;
        head_ptr_rd_req_rdy = 0; head_ptr_rd_resp_val = 0;
        head_ptr_rd_resp_addr = '0; head_ptr_rd_resp_data = '0;
        forever begin
            @(posedge clk); #1;
            if (head_ptr_rd_req_val && !rst) begin
                repeat (hd_rdy_dly) begin @(posedge clk); #1; end
                head_ptr_rd_req_rdy = 1;
                check("head_rd_pending", hd_q.size() != 0, 1);
                e = '{flow: '0, data: '0};
                if (hd_q.size() != 0) e = hd_q.pop_front();
                check("head_rd_addr", head_ptr_rd_req_addr, e.flow);
                @(posedge clk); #1;
                head_ptr_rd_req_rdy = 0;
                repeat (hd_resp_dly) begin @(posedge clk); #1; end
                head_ptr_rd_resp_val = 1; head_ptr_rd_resp_addr = e.flow; head_ptr_rd_resp_data = e.data;
                n = 0;
                do begin @(negedge clk); n++; end while (!head_ptr_rd_resp_rdy && n < 200);
                check("head_resp_accepted", head_ptr_rd_resp_rdy, 1);
                @(posedge clk); #1;
                head_ptr_rd_resp_val = 0;
            end
        end
    end

    // Tail pointer table responder
    initial begin
        ent_t e;
        int n;
        tail_ptr_rd_req_rdy = 0; tail_ptr_rd_resp_val = 0;
        tail_ptr_rd_resp_addr = '0; tail_ptr_rd_resp_data = '0;
        forever begin
            @(posedge clk); #1;
            if (tail_ptr_rd_req_val && !rst) begin
                repeat (tl_rdy_dly) begin @(posedge clk); #1; end
                tail_ptr_rd_req_rdy = 1;
                check("tail_rd_pending", tl_q.size() != 0, 1);
                e = '{flow: '0, data: '0};
                if (tl_q.size() != 0) e = tl_q.pop_front();
                check("tail_rd_addr", tail_ptr_rd_req_addr, e.flow);
                @(posedge clk); #1;
                tail_ptr_rd_req_rdy = 0;
                repeat (tl_resp_dly) begin @(posedge clk); #1; end
                tail_ptr_rd_resp_val = 1; tail_ptr_rd_resp_addr = e.flow; tail_ptr_rd_resp_data = e.data;
                n = 0;
                do begin @(negedge clk); n++; end while (!tail_ptr_rd_resp_rdy && n < 200);
                check("tail_resp_accepted", tail_ptr_rd_resp_rdy, 1);
                @(posedge clk); #1;
                tail_ptr_rd_resp_val = 0;
            end
        end
    end

    initial begin
        tail_ptr_wr_req_rdy = 0;
        forever begin
            @(posedge clk); #1;
            if (tail_ptr_wr_req_val) begin
                repeat (wr_dly) begin @(posedge clk); #1; end
                tail_ptr_wr_req_rdy = 1;
                @(posedge clk); #1;
                tail_ptr_wr_req_rdy = 0;
            end
        end
    end

    initial begin
        app_resp_rdy = 0;
        forever begin
            @(posedge clk); #1;
            if (app_resp_val) begin
                repeat (app_dly) begin @(posedge clk); #1; end
                app_resp_rdy = 1;
                @(posedge clk); #1;
                app_resp_rdy = 0;
            end
        end
    end

    // Monitor: scoreboard pops plus hold-stability while stalled
    initial begin
        ent_t w;
        rsp_t p;
        logic wr_hold, rsp_hold;
        fid_t h_wr_addr, h_rsp_flow;
        ptr_t h_wr_data, h_rsp_ptr;
        logic h_rsp_ok;
        wr_hold = 0; rsp_hold = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_hold = 0; rsp_hold = 0;
            end else begin
                if (wr_hold && tail_ptr_wr_req_val) begin
                    check("wr_hold_addr", tail_ptr_wr_req_addr, h_wr_addr);
                    check("wr_hold_data", tail_ptr_wr_req_data, h_wr_data);
                end
                if (rsp_hold && app_resp_val) begin
                    check("rsp_hold_flow", app_resp_flowid, h_rsp_flow);
                    check("rsp_hold_ok", app_resp_ok, h_rsp_ok);
                    check("rsp_hold_ptr", app_resp_ptr, h_rsp_ptr);
                end
                wr_hold  = tail_ptr_wr_req_val && !tail_ptr_wr_req_rdy;
                rsp_hold = app_resp_val && !app_resp_rdy;
                h_wr_addr = tail_ptr_wr_req_addr; h_wr_data = tail_ptr_wr_req_data;
                h_rsp_flow = app_resp_flowid; h_rsp_ok = app_resp_ok; h_rsp_ptr = app_resp_ptr;

                if (tail_ptr_wr_req_val && tail_ptr_wr_req_rdy) begin
                    n_wr++;
                    check("tail_wr_expected", wr_q.size() != 0, 1);
                    if (wr_q.size() != 0) begin
                        w = wr_q.pop_front();
                        check("tail_wr_addr", tail_ptr_wr_req_addr, w.flow);
                        check("tail_wr_data", tail_ptr_wr_req_data, w.data);
                    end
                end
                if (app_resp_val && app_resp_rdy) begin
                    n_resp++;
                    check("resp_expected", rsp_q.size() != 0, 1);
                    if (rsp_q.size() != 0) begin
                        p = rsp_q.pop_front();
                        check("resp_flowid", app_resp_flowid, p.flow);
                        check("resp_ok", app_resp_ok, p.ok);
                        check("resp_ptr", app_resp_ptr, p.ptr);
                        if (p.lat > 0) check("resp_latency", cyc - p.acc, p.lat);
                    end
                end
            end
        end
    end

    task automatic issue(input fid_t flow, input ptr_t len, input ptr_t hd, input ptr_t tl,
                         input logic do_wr, input ptr_t exp_wr, input logic exp_ok,
                         input ptr_t exp_ptr, input int lat, input logic expect_out,
                         output int acc);
        ent_t e;
        rsp_t p;
        int n;
        e.flow = flow; e.data = hd; hd_q.push_back(e);
        e.data = tl; tl_q.push_back(e);
        app_req_val = 1; app_req_flowid = flow; app_req_len = len;
        n = 0;
        do begin @(negedge clk); n++; end while (!app_req_rdy && n < 500);
        check("req_accept", app_req_rdy, 1);
        acc = cyc;
        if (expect_out) begin
            if (do_wr) begin
                e.flow = flow; e.data = exp_wr; wr_q.push_back(e);
            end
            p.flow = flow; p.ok = exp_ok; p.ptr = exp_ptr; p.acc = acc; p.lat = lat;
            rsp_q.push_back(p);
        end
        @(posedge clk); #1;
        app_req_val = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        check("drain_done", rsp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, w0, r0;
        rst = 1; app_req_val = 0; app_req_flowid = '0; app_req_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy_low", app_req_rdy, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_req_rdy", app_req_rdy, 1);
        check("post_rst_resp_val", app_resp_val, 0);
        check("post_rst_wr_val", tail_ptr_wr_req_val, 0);
        check("post_rst_hd_val", head_ptr_rd_req_val, 0);
        check("post_rst_tl_val", tail_ptr_rd_req_val, 0);
        check("post_rst_ok", app_resp_ok, 0);
        check("post_rst_ptr", app_resp_ptr, 0);
        check("post_rst_wr_data", tail_ptr_wr_req_data, 0);
        check("post_rst_wr_addr", tail_ptr_wr_req_addr, 0);
        check("post_rst_rd_addr", head_ptr_rd_req_addr, 0);
        @(posedge clk); #1;

        // empty flow, len=S: tail becomes S (wrap bit set)
        issue(4'd1, 7'd64, 7'd0, 7'd0, 1, 7'd64, 1, 7'd0, 4, 1, a1); drain();
        // full flow: denied
        issue(4'd2, 7'd1, 7'd0, 7'd64, 0, 7'd0, 0, 7'd64, 3, 1, a1); drain();
        // tail wraps past 127
        issue(4'd5, 7'd6, 7'd124, 7'd126, 1, 7'd4, 1, 7'd126, 4, 1, a1); drain();
        // len=0 and len=S+1 on empty flow
        w0 = n_wr;
        issue(4'd6, 7'd0, 7'd0, 7'd0, 0, 7'd0, 1, 7'd0, 3, 1, a1); drain();
        issue(4'd6, 7'd65, 7'd0, 7'd0, 0, 7'd0, 0, 7'd0, 3, 1, a1); drain();
        check("len0_oversize_no_wr", n_wr - w0, 0);
        // len exactly equals free (used=10, free=54), new tail 164 mod 128
        issue(4'd7, 7'd54, 7'd100, 7'd110, 1, 7'd36, 1, 7'd110, 4, 1, a1); drain();
        // back-to-back
        issue(4'd8, 7'd10, 7'd0, 7'd0, 1, 7'd10, 1, 7'd0, 4, 1, a1);
        issue(4'd8, 7'd5, 7'd0, 7'd10, 1, 7'd15, 1, 7'd10, 4, 1, a2);
        check("b2b_accept_gap", a2 - a1, 5);
        drain();

        // skewed handshakes
        hd_rdy_dly = 3; tl_resp_dly = 5; wr_dly = 2; app_dly = 4;
        w0 = n_wr; r0 = n_resp;
        issue(4'd3, 7'd5, 7'd10, 7'd20, 1, 7'd25, 1, 7'd20, 0, 1, a1); drain();
        check("skew_single_wr", n_wr - w0, 1);
        check("skew_single_resp", n_resp - r0, 1);
        hd_rdy_dly = 0; tl_resp_dly = 0; wr_dly = 0; app_dly = 0;

        // reset while stalled in WR_TAIL
        wr_dly = 20;
        w0 = n_wr; r0 = n_resp;
        issue(4'd4, 7'd8, 7'd0, 7'd0, 1, 7'd8, 1, 7'd0, 0, 0, a1);
        begin
            int n;
            n = 0;
            while (!tail_ptr_wr_req_val && n < 100) begin @(negedge clk); n++; end
            check("abort_reached_wr", tail_ptr_wr_req_val, 1);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check("abort_rst_req_rdy", app_req_rdy, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("abort_post_req_rdy", app_req_rdy, 1);
        check("abort_post_wr_val", tail_ptr_wr_req_val, 0);
        check("abort_post_resp_val", app_resp_val, 0);
        repeat (25) @(posedge clk);
        #1 wr_dly = 0;
        check("abort_no_wr", n_wr - w0, 0);
        check("abort_no_resp", n_resp - r0, 0);
        issue(4'd9, 7'd2, 7'd3, 7'd8, 1, 7'd10, 1, 7'd8, 4, 1, a1); drain();

        check("wr_q_empty", wr_q.size(), 0);
        check("hd_q_empty", hd_q.size(), 0);
        check("tl_q_empty", tl_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_app_buf_alloc.md
TX_APP_BUF_ALLOC -- requirements
Module: tx_app_buf_alloc

Interface
REQ-001 Parameters SHALL be none; widths SHALL come from tcp_pkg: FLOWID_W and TX_PAYLOAD_PTR_W (P = TX_PAYLOAD_PTR_W+1 pointer bits incl. wrap bit; buffer size S = 2^TX_PAYLOAD_PTR_W bytes).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 app_req_val/app_req_rdy  in/out  1  application allocation request handshake.
REQ-005 app_req_flowid  in  FLOWID_W  flow to allocate in; app_req_len  in  P  bytes requested.
REQ-006 app_resp_val/app_resp_rdy  out/in  1  allocation response handshake.
REQ-007 app_resp_flowid  out  FLOWID_W; app_resp_ok  out  1  grant; app_resp_ptr  out  P  tail pointer before allocation (write start).
REQ-008 head_ptr_rd_req_val/addr/rdy  out/out/in  1/FLOWID_W/1  head pointer read request.
REQ-009 head_ptr_rd_resp_val/addr/data/rdy  in/in/in/out  1/FLOWID_W/P/1  head pointer read response.
REQ-010 tail_ptr_rd_req_* and tail_ptr_rd_resp_*  same widths/directions as REQ-008/009, for tail pointer.
REQ-011 tail_ptr_wr_req_val/addr/data/rdy  out/out/out/in  1/FLOWID_W/P/1  tail pointer update.

Function
REQ-012 All handshakes SHALL transfer on val & rdy in the same cycle; val SHALL NOT depend combinationally on the matching rdy.
REQ-013 FSM states SHALL be IDLE, RD_REQ, RD_RESP, WR_TAIL, RESP.
REQ-014 IDLE: app_req_rdy=1; on app_req handshake, latch flowid and len, clear issued/received flags, go RD_REQ.
REQ-015 RD_REQ: assert head and tail read req_val (addr = latched flowid) until each is individually accepted; the two may be accepted in different cycles; once both are accepted go RD_RESP.
REQ-016 RD_RESP: head/tail resp_rdy=1 for a port until its response is captured; capture data on handshake; once both are captured compute the result (REQ-017) and go WR_TAIL if granted with len!=0, else RESP.
REQ-017 Arithmetic: used = (tail - head) mod 2^P; free = S - used; grant = (len <= free); new_tail = (tail + len) mod 2^P. All computation SHALL be P bits with natural wrap.
REQ-018 WR_TAIL: tail_ptr_wr_req_val=1, addr = flowid, data = new_tail; hold all fields stable until rdy; then go RESP.
REQ-019 RESP: app_resp_val=1, flowid = latched value, ok = grant, ptr = captured tail; hold stable until rdy; then go IDLE.
REQ-020 One request SHALL be outstanding at a time; app_req_rdy=0 outside IDLE.
REQ-021 Minimum latency, all rdy high: req accept cycle 0, reads cycle 1, responses captured cycle 2 (or on arrival), tail write 1 cycle, response 1 cycle; back-to-back requests SHALL see no extra idle cycle beyond IDLE.
REQ-022 Boundaries: len=0 -> ok=1, no tail write; len=free -> ok=1 (buffer full afterward); len>free or len>S -> ok=0, no tail write; tail wrap past 2^P-1 SHALL wrap to low values.
REQ-023 Tail pointer write SHALL occur only after both reads complete (no write before read-back of same flow).

Reset
REQ-024 During rst the FSM SHALL enter IDLE and all val outputs and latched flags SHALL clear, next cycle; app_req_rdy SHALL be 0 while rst=1 and 1 in the first cycle after.
REQ-025 Reset mid-transaction SHALL abandon it with no tail write and no response; late read responses arriving after reset SHALL be accepted (resp_rdy=1 in IDLE) and discarded.
REQ-026 Data outputs (addr, data, ptr, ok) SHALL reset to 0.

Verification
REQ-027 Empty flow: head=0, tail=0, len=S -> tail write data=S (wrap bit set), resp ok=1, ptr=0.
REQ-028 Full flow: head=0, tail=S, len=1 -> no tail write, resp ok=0, ptr=S.
REQ-029 Wrap: head=2^P-4, tail=2^P-2, len=6 -> tail write data=4, ok=1, ptr=2^P-2.
REQ-030 Skewed handshakes: head read rdy delayed 3 cycles, tail resp delayed 5 cycles, tail_wr rdy low 2 cycles, app_resp_rdy low 4 cycles -> single tail write, single correct response, outputs stable while stalled.
REQ-031 len=0 and oversize len=S+1 on empty flow -> ok=1 and ok=0 respectively, zero tail writes.
REQ-032 rst asserted in WR_TAIL while rdy=0 -> no write/response issued; next request completes normally.
